// File: rtl/timer_pkg.sv
// Shared types and default sizes for the multi-channel timer.
package timer_pkg;

  typedef enum logic {
    ONESHOT  = 1'b0,
    PERIODIC = 1'b1
  } timer_mode_e;

  localparam int TIMER_WIDTH   = 32;
  localparam int TIMER_PRESC_W = 8;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, down counter, mode and expiry detection.
// 'expire' marks the edge on which this channel expires; the top level
// uses it to set the channel's sticky pending flag.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH   = TIMER_WIDTH,
  parameter int PRESC_W = TIMER_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   set_val,
  input  logic [PRESC_W-1:0] set_div,
  input  logic               set_mode,
  input  logic               stop,
  output logic               timer_is_high,
  output logic               expire
);

  logic               armed;
  timer_mode_e        mode;
  logic [WIDTH-1:0]   reload;
  logic [PRESC_W-1:0] div;
  logic [WIDTH-1:0]   cnt;
  logic [PRESC_W-1:0] pre;
  logic               pulse;

  logic cnt_zero;
  logic cnt_exp;
  logic load_zero;

  assign cnt_zero  = (cnt == '0);
  assign load_zero = (set_val == '0);

  // The count expires on the last prescaled tick, or on every armed edge
  // while a PERIODIC channel sits at zero (reload of 0 gives a pulse per cycle).
  assign cnt_exp = armed & (((cnt == WIDTH'(1)) & (pre == '0)) |
                            ((mode == PERIODIC) & cnt_zero));

  // A load of 0 expires on the load edge itself; otherwise load beats the
  // old count's expiry, and stop suppresses it.
  assign expire = load ? load_zero : (~stop & cnt_exp);

  assign timer_is_high = (armed & (mode == ONESHOT) & cnt_zero) | pulse;

  // Channel state: load beats stop, stop beats counting; pulse lasts one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed  <= 1'b0;
      mode   <= ONESHOT;
      reload <= '0;
      div    <= '0;
      cnt    <= '0;
      pre    <= '0;
      pulse  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (load) begin
        armed  <= 1'b1;
        mode   <= timer_mode_e'(set_mode);
        reload <= set_val;
        cnt    <= set_val;
        div    <= set_div;
        pre    <= set_div;
        pulse  <= load_zero & (timer_mode_e'(set_mode) == PERIODIC);
      end else if (stop) begin
        armed <= 1'b0;
      end else if (armed) begin
        if (cnt_exp) begin
          pre <= div;
          if (mode == PERIODIC) begin
            cnt   <= reload;
            pulse <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end else if (!cnt_zero) begin
          if (pre == '0) begin
            pre <= div;
            cnt <= cnt - WIDTH'(1);
          end else begin
            pre <= pre - PRESC_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/multi_channel_timer.sv
// NUM_CH independent prescaled down-count timers with sticky, clearable
// per-channel interrupt flags and a combined interrupt line.
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = TIMER_WIDTH,
  parameter int PRESC_W = TIMER_PRESC_W,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_timer,
  input  logic [CH_W-1:0]    set_ch,
  input  logic [WIDTH-1:0]   set_val,
  input  logic [PRESC_W-1:0] set_div,
  input  logic               set_mode,
  input  logic [NUM_CH-1:0]  stop,
  input  logic [NUM_CH-1:0]  irq_clr,
  output logic [NUM_CH-1:0]  timer_is_high,
  output logic [NUM_CH-1:0]  irq_pending,
  output logic               irq
);

  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] expire;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // Out-of-range channel selects match no k and are dropped.
    assign load[k] = set_timer & (set_ch == CH_W'(k));

    timer_channel #(
      .WIDTH   (WIDTH),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .load          (load[k]),
      .set_val       (set_val),
      .set_div       (set_div),
      .set_mode      (set_mode),
      .stop          (stop[k]),
      .timer_is_high (timer_is_high[k]),
      .expire        (expire[k])
    );
  end

  // Sticky expiry flags; a new expiry wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_pending <= '0;
    else      irq_pending <= (irq_pending & ~irq_clr) | expire;
  end

  assign irq = |irq_pending;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer; a second 3-channel instance
// shares the inputs so that set_ch=3 is an out-of-range select for it.
module tb_multi_channel_timer;

  logic        clk;
  logic        rst;
  logic        set_timer;
  logic [1:0]  set_ch;
  logic [31:0] set_val;
  logic [7:0]  set_div;
  logic        set_mode;
  logic [3:0]  stop;
  logic [3:0]  irq_clr;
  logic [3:0]  tih;
  logic [3:0]  pend;
  logic        irq;
  logic [2:0]  tih3;
  logic [2:0]  pend3;
  logic        irq3;

  int n_cmp = 0;
  int n_err = 0;

  multi_channel_timer dut (
    .clk(clk), .rst(rst), .set_timer(set_timer), .set_ch(set_ch),
    .set_val(set_val), .set_div(set_div), .set_mode(set_mode),
    .stop(stop), .irq_clr(irq_clr), .timer_is_high(tih),
    .irq_pending(pend), .irq(irq)
  );

  multi_channel_timer #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .set_timer(set_timer), .set_ch(set_ch),
    .set_val(set_val), .set_div(set_div), .set_mode(set_mode),
    .stop(stop[2:0]), .irq_clr(irq_clr[2:0]), .timer_is_high(tih3),
    .irq_pending(pend3), .irq(irq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int val, input int dv, input bit md);
    set_timer = 1'b1;
    set_ch    = ch[1:0];
    set_val   = val;
    set_div   = dv[7:0];
    set_mode  = md;
    tick();
    set_timer = 1'b0;
  endtask

  task automatic clear_all();
    stop = '1; irq_clr = '1;
    tick();
    stop = '0; irq_clr = '0;
  endtask

  initial begin
    int n;
    int exp_n;
    int idx;
    int ch;
    int dvs[3] = '{0, 1, 7};

    rst = 1'b0; set_timer = 1'b0; set_ch = '0; set_val = '0;
    set_div = '0; set_mode = 1'b0; stop = '0; irq_clr = '0;
    #22;
    chk("rst_tih", {28'd0, tih}, 32'd0);
    chk("rst_pend", {28'd0, pend}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;
    tick();

    // 1: ONESHOT val=5 div=0 -> low 5 cycles, high from the 6th, sticky.
    load(0, 5, 0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t1_tih0_c%0d", i), {31'd0, tih[0]}, {31'd0, i >= 5});
      tick();
    end
    chk("t1_pend0", {31'd0, pend[0]}, 32'd1);
    chk("t1_irq", {31'd0, irq}, 32'd1);
    clear_all();
    chk("t1_stop_tih0", {31'd0, tih[0]}, 32'd0);
    chk("t1_clr_pend", {28'd0, pend}, 32'd0);

    // 2: PERIODIC val=3 div=2 -> 1-cycle pulse every 9 cycles.
    load(1, 3, 2, 1'b1);
    for (int i = 0; i < 27; i++) begin
      chk($sformatf("t2_tih1_c%0d", i), {31'd0, tih[1]}, {31'd0, (i > 0) && (i % 9 == 0)});
      if (i == 8) chk("t2_pend1_pre", {31'd0, pend[1]}, 32'd0);
      if (i == 9) chk("t2_pend1_set", {31'd0, pend[1]}, 32'd1);
      tick();
    end
    chk("t2_tih1_c27", {31'd0, tih[1]}, 32'd1);
    irq_clr[1] = 1'b1;
    tick();
    irq_clr[1] = 1'b0;
    chk("t2_pend1_clr", {31'd0, pend[1]}, 32'd0);
    repeat (7) tick();
    irq_clr[1] = 1'b1;
    tick();
    irq_clr[1] = 1'b0;
    chk("t2_tih1_c36", {31'd0, tih[1]}, 32'd1);
    chk("t2_set_beats_clr", {31'd0, pend[1]}, 32'd1);
    stop[1] = 1'b1;
    tick();
    stop[1] = 1'b0;
    chk("t2_stop_tih1", {31'd0, tih[1]}, 32'd0);

    // 3: val=0 expires on the load edge; PERIODIC val=0 pulses every cycle.
    load(2, 0, 0, 1'b0);
    chk("t3_os_tih2", {31'd0, tih[2]}, 32'd1);
    chk("t3_os_pend2", {31'd0, pend[2]}, 32'd1);
    load(2, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_per_tih2_c%0d", i), {31'd0, tih[2]}, 32'd1);
      tick();
    end
    clear_all();
    chk("t3_stop_tih", {28'd0, tih}, 32'd0);
    chk("t3_irq_clr", {31'd0, irq}, 32'd0);

    // 4: stop mid-count holds output low; load beats a same-edge stop.
    load(0, 10, 0, 1'b0);
    repeat (3) tick();
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (tih[0]) n++;
      tick();
    end
    chk("t4_stopped_highs", n, 0);
    chk("t4_stopped_pend0", {31'd0, pend[0]}, 32'd0);
    stop[0] = 1'b1;
    load(0, 2, 0, 1'b0);
    stop[0] = 1'b0;
    chk("t4_reload_c0", {31'd0, tih[0]}, 32'd0);
    tick();
    chk("t4_reload_c1", {31'd0, tih[0]}, 32'd0);
    tick();
    chk("t4_reload_c2", {31'd0, tih[0]}, 32'd1);

    // 5: asynchronous reset mid-count clears everything; no resume.
    load(3, 4, 0, 1'b0);
    tick();
    chk("t5_pre_rst_tih", {28'd0, tih}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_tih", {28'd0, tih}, 32'd0);
    chk("t5_async_pend", {28'd0, pend}, 32'd0);
    chk("t5_async_irq", {31'd0, irq}, 32'd0);
    tick();
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tih != 4'd0 || irq) n++;
    end
    chk("t5_no_resume", n, 0);

    // 6: latency sweep with a load to a neighbouring channel during the count.
    for (int d = 0; d < 3; d++) begin
      for (int v = 0; v <= 64; v++) begin
        ch = (v + d) % 4;
        exp_n = v * (dvs[d] + 1);
        load(ch, v, dvs[d], 1'b0);
        n = 0;
        while (!tih[ch] && n < 1000) begin
          if (n == 0) begin
            idx = (ch + 1) % 4;
            load(idx, int'($urandom_range(1, 20)), int'($urandom_range(0, 3)), 1'b0);
          end else begin
            tick();
          end
          n++;
        end
        chk($sformatf("t6_lat_ch%0d_v%0d_d%0d", ch, v, dvs[d]), n, exp_n);
      end
    end

    // Out-of-range select: channel 3 does not exist on the 3-channel instance.
    clear_all();
    chk("oor_pre_irq3", {31'd0, irq3}, 32'd0);
    load(3, 0, 0, 1'b0);
    chk("oor_main_tih3", {31'd0, tih[3]}, 32'd1);
    chk("oor_dut3_tih", {29'd0, tih3}, 32'd0);
    chk("oor_dut3_pend", {29'd0, pend3}, 32'd0);
    load(2, 1, 0, 1'b0);
    tick();
    chk("oor_dut3_ch2", {29'd0, tih3}, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
